// File: rtl/cbfp_pkg.sv
// rtl/cbfp_pkg.sv - shared state, tag types and default sizes for the CBFP shift-register sequencer
package cbfp_pkg;

  localparam int ARRAY_SIZE_DEF = 16;
  localparam int BUF_DEPTH_DEF  = 64;
  localparam int BLOCKS_DEF     = 8;
  localparam int EXP_W_DEF      = 5;
  localparam int BEAT_W         = $clog2(BUF_DEPTH_DEF / ARRAY_SIZE_DEF);
  localparam int BLK_W          = $clog2(BLOCKS_DEF);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    FLUSH
  } sr_state_e;

  typedef struct packed {
    logic              valid;
    logic [BEAT_W-1:0] beat;
    logic [BLK_W-1:0]  blk;
    logic              last;
  } sr_tag_t;

endpackage

// File: rtl/cbfp_exp_tracker.sv
// rtl/cbfp_exp_tracker.sv - running-minimum exponent per block, latched on the block's final beat
module cbfp_exp_tracker
  import cbfp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             first_beat,
  input  logic             final_beat,
  input  logic [EXP_W-1:0] exp_in,
  output logic [EXP_W-1:0] blk_exp
);

  logic [EXP_W-1:0] acc;
  logic [EXP_W-1:0] run_min;

  // Beat 0 restarts the minimum so the previous block never leaks in
  always_comb begin
    run_min = exp_in;
    if (!first_beat && (acc < exp_in)) run_min = acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      blk_exp <= '0;
    end else if (accept) begin
      acc <= run_min;
      if (final_beat) blk_exp <= run_min;
    end
  end

endmodule

// File: rtl/cbfp_sr_ctrl.sv
// rtl/cbfp_sr_ctrl.sv - shift-register output buffer sequencer; CBFP_SR_CTRL_EXP_EN enables the block exponent tracker
module cbfp_sr_ctrl
  import cbfp_pkg::*;
#(
  parameter  int ARRAY_SIZE       = ARRAY_SIZE_DEF,
  parameter  int BUF_DEPTH        = BUF_DEPTH_DEF,
  parameter  int BLOCKS_PER_FRAME = BLOCKS_DEF,
  parameter  int EXP_W            = EXP_W_DEF,
  localparam int BPB              = BUF_DEPTH / ARRAY_SIZE,
  localparam int BW               = $clog2(BPB),
  localparam int KW               = $clog2(BLOCKS_PER_FRAME)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [EXP_W-1:0] exp_in,
  output logic             in_ready,
  output logic             shift_en,
  output logic             out_valid,
  output logic [BW-1:0]    out_beat,
  output logic [KW-1:0]    out_blk,
  output logic             out_last,
  output logic [EXP_W-1:0] blk_exp,
  output logic             frame_done,
  output logic             ovf_err
);

  localparam logic [BW-1:0] BEAT_LAST = BW'(BPB - 1);
  localparam logic [KW-1:0] BLK_LAST  = KW'(BLOCKS_PER_FRAME - 1);

  sr_state_e     state, state_nx;
  logic [BW-1:0] in_beat;
  logic [KW-1:0] in_blk;
  logic [1:0]    flush_cnt;
  sr_tag_t       tag [4];
  logic          tap_new;
  logic          accept, beat_last, blk_last, flush_end;

  assign accept    = valid_in & in_ready;
  assign beat_last = (in_beat == BEAT_LAST);
  assign blk_last  = (in_blk == BLK_LAST);
  assign flush_end = (state == FLUSH) && (flush_cnt == 2'd2);
  assign shift_en  = accept | (state == FLUSH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = FILL;
      FILL:    if (accept && beat_last) state_nx = STREAM;
      STREAM:  if (accept && beat_last && blk_last) state_nx = FLUSH;
      FLUSH:   if (flush_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready   <= 1'b0;
      in_beat    <= '0;
      in_blk     <= '0;
      flush_cnt  <= 2'd0;
      ovf_err    <= 1'b0;
      frame_done <= 1'b0;
      tap_new    <= 1'b0;
      for (int i = 0; i < 4; i++) tag[i] <= '0;
    end else begin
      in_ready   <= (state_nx != FLUSH);
      ovf_err    <= ovf_err | (valid_in & ~in_ready);
      frame_done <= flush_end;
      // Tap data is reported once, on the cycle right after the shift that delivered it
      tap_new    <= shift_en;
      if (accept) begin
        in_beat <= in_beat + 1'b1;
        if (beat_last) in_blk <= blk_last ? '0 : in_blk + 1'b1;
      end
      if (state == FLUSH) flush_cnt <= flush_end ? 2'd0 : flush_cnt + 2'd1;
      if (shift_en) begin
        tag[0] <= '{valid: accept, beat: in_beat, blk: in_blk,
                    last: accept & beat_last & blk_last};
        for (int i = 1; i < 4; i++) tag[i] <= tag[i-1];
      end
    end
  end

  assign out_valid = tag[3].valid & tap_new;
  assign out_beat  = tag[3].beat;
  assign out_blk   = tag[3].blk;
  assign out_last  = tag[3].last;

`ifdef CBFP_SR_CTRL_EXP_EN
  cbfp_exp_tracker #(.EXP_W(EXP_W)) u_exp_tracker (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .first_beat(in_beat == '0),
    .final_beat(beat_last),
    .exp_in    (exp_in),
    .blk_exp   (blk_exp)
  );
`else
  logic unused_exp;
  assign unused_exp = ^exp_in;
  assign blk_exp    = '0;
`endif

endmodule
